// File: rtl/csel_adder_pipe.sv
// ---------------------------------------------------------------------------
// csel_adder_pipe
//
// Pipelined carry-select adder/subtractor with valid/ready handshaking on
// both sides. The WIDTH-bit operation is split into NBLK = WIDTH/BLK blocks.
// Stage k resolves block k: it forms the block sum for carry-in 0 and for
// carry-in 1, then picks one using the carry registered by stage k-1.
// Operand blocks not yet consumed travel alongside in skew registers.
//
// Optional feature macro: CSEL_SUB_EN
//   defined   : sub=1 computes a - b (b inverted, carry-in forced to 1)
//   undefined : sub is accepted but ignored; always a + b + cin
//
// Parameters
//   WIDTH     operand / sum width (default 16)
//   BLK       carry-select block width (default 4); WIDTH % BLK must be 0
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat offered
//   in_ready   beat accepted this cycle when in_valid is also 1
//   a, b       operands
//   cin        carry-in (ignored for subtract)
//   sub        1 = subtract (only with CSEL_SUB_EN)
//   out_valid  result beat present
//   out_ready  downstream takes the result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
// ---------------------------------------------------------------------------
module csel_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = (BLK >= 1) ? (WIDTH / BLK) : 1;

    if (BLK < 1) begin : g_bad_blk
        $error("csel_adder_pipe: BLK must be at least 1");
    end else if ((WIDTH % BLK) != 0) begin : g_bad_width
        $error("csel_adder_pipe: WIDTH must be a multiple of BLK");
    end

    // Index k of these arrays is the input side of stage k; index k+1 is the
    // register output of stage k. w_a carries the partially summed word: each
    // stage rotates it right by BLK and drops its block sum into the top, so
    // after NBLK stages the word is the finished sum in natural bit order.
    logic [WIDTH-1:0] w_a [0:NBLK];
    logic [WIDTH-1:0] w_b [0:NBLK-1];
    logic             w_c [0:NBLK];
    logic             w_v [0:NBLK];
    logic             w_ovf;
    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

`ifdef CSEL_SUB_EN
    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub ? 1'b1 : cin;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_b_eff      = b;
    assign w_c0         = cin;
`endif

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign w_adv    = !w_v[NBLK] || out_ready;
    assign in_ready = w_adv;

    assign w_a[0] = a;
    assign w_b[0] = w_b_eff;
    assign w_c[0] = w_c0;
    assign w_v[0] = in_valid;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [BLK:0]     w_r0;
        logic [BLK:0]     w_r1;
        logic [BLK:0]     w_sel;
        logic [WIDTH-1:0] w_a_nxt;
        logic [WIDTH-1:0] r_a;
        logic             r_c;
        logic             r_v;

        assign w_r0  = {1'b0, w_a[k][BLK-1:0]} + {1'b0, w_b[k][BLK-1:0]};
        assign w_r1  = {1'b0, w_a[k][BLK-1:0]} + {1'b0, w_b[k][BLK-1:0]}
                     + {{BLK{1'b0}}, 1'b1};
        assign w_sel = w_c[k] ? w_r1 : w_r0;

        if (NBLK == 1) begin : g_single
            assign w_a_nxt = w_sel[BLK-1:0];
        end else begin : g_rot
            assign w_a_nxt = {w_sel[BLK-1:0], w_a[k][WIDTH-1:BLK]};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= 1'b0;
                r_a <= '0;
                r_c <= 1'b0;
            end else if (w_adv) begin
                r_v <= w_v[k];
                if (w_v[k]) begin
                    r_a <= w_a_nxt;
                    r_c <= w_sel[BLK];
                end
            end
        end

        assign w_a[k+1] = r_a;
        assign w_c[k+1] = r_c;
        assign w_v[k+1] = r_v;

        if (k < NBLK - 1) begin : g_skew
            // Rotate so the next stage finds its operand block at the bottom.
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_b <= '0;
                end else if (w_adv && w_v[k]) begin
                    r_b <= {w_b[k][BLK-1:0], w_b[k][WIDTH-1:BLK]};
                end
            end

            assign w_b[k+1] = r_b;
        end else begin : g_last
            // Carry into the MSB recovered from the MSB's own sum bit.
            logic w_cmsb;
            logic r_ovf;

            assign w_cmsb = w_sel[BLK-1] ^ w_a[k][BLK-1] ^ w_b[k][BLK-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv && w_v[k]) begin
                    r_ovf <= w_cmsb ^ w_sel[BLK];
                end
            end

            assign w_ovf = r_ovf;
        end
    end

    assign out_valid = w_v[NBLK];
    assign sum       = w_a[NBLK];
    assign cout      = w_c[NBLK];
    assign ovf       = w_ovf;

endmodule

// File: tb/tb_csel_adder_pipe.sv
module tb_csel_adder_pipe;

    localparam int W   = 16;
    localparam int B   = 4;
    localparam int LAT = W / B;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    csel_adder_pipe #(.WIDTH(W), .BLK(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;   // 0: out_ready=1, 1: random, 2: driven by the test
    logic [W+1:0] sbq[$];
    bit           hold_pending = 0;
    logic [W+1:0] hold_val;

    // Reference: integer arithmetic; returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                           input logic tc, input logic ts);
        longint ua, ub, sa, sb, full, s, lim;
        logic   c, o, do_sub;
        lim = longint'(1) << W;
        ua  = longint'(ta);
        ub  = longint'(tb_);
        sa  = (ua >= lim / 2) ? ua - lim : ua;
        sb  = (ub >= lim / 2) ? ub - lim : ub;
`ifdef CSEL_SUB_EN
        do_sub = ts;
`else
        do_sub = 1'b0 & ts;
`endif
        if (do_sub) begin
            full = ua - ub;
            c    = (ua >= ub);
            s    = sa - sb;
        end else begin
            full = ua + ub + longint'(tc);
            c    = (full >= lim);
            s    = sa + sb + longint'(tc);
        end
        o = (s >= lim / 2) || (s < -(lim / 2));
        return {o, c, full[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 0;
        end else begin
            if (hold_pending)
                chk("hold", {out_valid, ovf, cout, sum}, {1'b1, hold_val});
            hold_pending = out_valid && !out_ready;
            if (hold_pending) begin
                hold_val = {ovf, cout, sum};
                chk("stall_in_ready", {{(W+1){1'b0}}, in_ready}, '0);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", {ovf, cout, sum}, 'x);
                end else begin
                    chk("result", {ovf, cout, sum}, sbq.pop_front());
                end
            end
        end
    end

    // Background out_ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = (($urandom % 4) != 0);
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts);
        int n = 0;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(model(ta, tb_, tc, ts));
                break;
            end
            n++;
            if (n > 1000) begin
                chk("send_timeout", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        int n = 0;
        in_valid  = 1'b0;
        rdy_mode  = 0;
        out_ready = 1'b1;
        while ((sbq.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", {{(W+1){1'b0}}, (sbq.size() == 0 && !out_valid)}, {{(W+1){1'b0}}, 1'b1});
    endtask

    task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tc, input logic ts, input logic [W+1:0] exp);
        int lat = 1;
        wait_empty();
        send(ta, tb_, tc, ts);
        in_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 50) break;
            lat++;
            @(posedge clk);
        end
        chk({name, "_latency"}, (W+2)'(lat), (W+2)'(LAT));
        chk(name, {ovf, cout, sum}, exp);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] sa_arr [0:5];
    logic [W-1:0] sb_arr [0:5];

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {out_valid, ovf, cout, sum}, '0);
        chk("reset_in_ready", {{(W+1){1'b0}}, in_ready}, {{(W+1){1'b0}}, 1'b1});
        @(posedge clk);
        #1;
        rst = 1'b0;

        directed("wrap_ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        directed("ovf_7fff_plus_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        directed("add_with_cin",     16'h1234, 16'h0FFF, 1'b1, 1'b0, {1'b0, 1'b0, 16'h2234});
        directed("neg_ovf",          16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
`ifdef CSEL_SUB_EN
        directed("sub_5_minus_7",    16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
`else
        directed("sub_ignored",      16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'h000D});
`endif

        // Six back-to-back beats with out_ready low in cycles 5..7
        wait_empty();
        for (int i = 0; i < 6; i++) begin
            sa_arr[i] = W'($urandom);
            sb_arr[i] = W'($urandom);
        end
        rdy_mode = 2;
        begin
            int n = 0;
            for (int cyc = 1; cyc <= 40 && n < 6; cyc++) begin
                out_ready = !(cyc >= 5 && cyc <= 7);
                in_valid  = 1'b1;
                a = sa_arr[n]; b = sb_arr[n]; cin = cyc[0]; sub = 1'b0;
                @(negedge clk);
                if (cyc >= 5 && cyc <= 7) begin
                    chk("stall_out_valid", {{(W+1){1'b0}}, out_valid}, {{(W+1){1'b0}}, 1'b1});
                    chk("stall_no_accept", {{(W+1){1'b0}}, in_ready}, '0);
                end
                if (in_ready) begin
                    sbq.push_back(model(a, b, cin, sub));
                    n++;
                end
                @(posedge clk);
                #1;
            end
            chk("stall_beats_sent", (W+2)'(n), (W+2)'(6));
        end
        wait_empty();

        // Reset with three beats in flight
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b1, 1'b0);
        send(16'h5555, 16'h6666, 1'b0, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555;
        @(negedge clk);
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_out_valid", {{(W+1){1'b0}}, out_valid}, '0);
        @(posedge clk);
        #1;
        idle(12);
        chk("post_reset_nothing_queued", (W+2)'(sbq.size()), '0);

        // Random traffic with random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            if (($urandom % 5) == 0) idle(1);
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
